fibonacci_checker: RTL and testbench

//  Consumer end of the Fibonacci stream: accepts 1 or 2 numbers per beat over valid/ready.

---
 rtl/fib_pkg.sv | 22 ++
 rtl/fib_step.sv | 27 ++
 rtl/fibonacci_checker.sv | 120 ++++++++++++
 tb/tb_fibonacci_checker.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// Shared types and defaults for the Fibonacci generator/checker family.
// FIB_NUM_T gives a WIDTH-sized number type to any module that has its own WIDTH parameter.
`ifndef FIB_PKG_SV
`define FIB_PKG_SV

`define FIB_NUM_T(W) logic [(W)-1:0]

package fib_pkg;

  typedef enum logic {
    CHECK = 1'b0,
    HALT  = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_SEED0 = 1;
  localparam int DEF_SEED1 = 1;
  localparam int DEF_CNT_W = 16;

endpackage

`endif

// File: rtl/fib_step.sv
// One Fibonacci advance: by one term (two=0) or by two terms (two=1), modulo 2^WIDTH.
// carry flags any overflow in a+b or a+2b; shared with the generators.
module fib_step
  import fib_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  `FIB_NUM_T(WIDTH) i_a,
  input  `FIB_NUM_T(WIDTH) i_b,
  input  logic             i_two,
  output `FIB_NUM_T(WIDTH) o_next_a,
  output `FIB_NUM_T(WIDTH) o_next_b,
  output logic             o_carry
);

  logic [WIDTH:0] w_sum1;
  logic [WIDTH:0] w_sum2;

  // a+2b is built on the wrapped a+b, so its own carry only matters when a+b did not overflow
  assign w_sum1 = {1'b0, i_a} + {1'b0, i_b};
  assign w_sum2 = {1'b0, w_sum1[WIDTH-1:0]} + {1'b0, i_b};

  assign o_next_a = i_two ? w_sum1[WIDTH-1:0] : i_b;
  assign o_next_b = i_two ? w_sum2[WIDTH-1:0] : w_sum1[WIDTH-1:0];
  assign o_carry  = w_sum1[WIDTH] | (i_two & w_sum2[WIDTH]);

endmodule

// File: rtl/fibonacci_checker.sv
// Consumer end of the Fibonacci stream: checks 1 or 2 numbers per beat against the
// internally generated sequence, captures the first mismatch and halts until cleared.
module fibonacci_checker
  import fib_pkg::*;
#(
  parameter int          WIDTH = DEF_WIDTH,
  parameter int unsigned SEED0 = DEF_SEED0,
  parameter int unsigned SEED1 = DEF_SEED1,
  parameter int          CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_two,
  input  `FIB_NUM_T(WIDTH) in_num0,
  input  `FIB_NUM_T(WIDTH) in_num1,
  output logic [CNT_W-1:0] count,
  output logic             wrapped,
  output logic             err,
  output logic [CNT_W-1:0] err_idx,
  output `FIB_NUM_T(WIDTH) err_expected,
  output `FIB_NUM_T(WIDTH) err_got
);

  state_t             r_state;
  `FIB_NUM_T(WIDTH)   r_a;
  `FIB_NUM_T(WIDTH)   r_b;
  logic [CNT_W-1:0]   r_count;
  logic               r_wrapped;
  logic               r_err;
  logic [CNT_W-1:0]   r_err_idx;
  `FIB_NUM_T(WIDTH)   r_err_expected;
  `FIB_NUM_T(WIDTH)   r_err_got;

  logic               w_accept;
  logic               w_lane0_ok;
  logic               w_lane1_ok;
  `FIB_NUM_T(WIDTH)   w_next_a;
  `FIB_NUM_T(WIDTH)   w_next_b;
  logic               w_carry;
  logic [CNT_W-1:0]   w_count_p1;
  logic [CNT_W-1:0]   w_count_p2;

  function automatic logic [CNT_W-1:0] satAdd(input logic [CNT_W-1:0] v, input logic [1:0] inc);
    logic [CNT_W:0] s;
    s = {1'b0, v} + {{(CNT_W-1){1'b0}}, inc};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  fib_step #(.WIDTH(WIDTH)) u_step (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_two    (in_two),
    .o_next_a (w_next_a),
    .o_next_b (w_next_b),
    .o_carry  (w_carry)
  );

  assign in_ready   = (r_state == CHECK) & ~clear;
  assign w_accept   = in_valid & in_ready;
  assign w_lane0_ok = (in_num0 == r_a);
  assign w_lane1_ok = (in_num1 == r_b);
  assign w_count_p1 = satAdd(r_count, 2'd1);
  assign w_count_p2 = satAdd(r_count, 2'd2);

  // clear restarts everything, including the sticky wrap flag, so a rerun starts clean
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= CHECK;
      r_a            <= WIDTH'(SEED0);
      r_b            <= WIDTH'(SEED1);
      r_count        <= '0;
      r_wrapped      <= 1'b0;
      r_err          <= 1'b0;
      r_err_idx      <= '0;
      r_err_expected <= '0;
      r_err_got      <= '0;
    end else if (clear) begin
      r_state        <= CHECK;
      r_a            <= WIDTH'(SEED0);
      r_b            <= WIDTH'(SEED1);
      r_count        <= '0;
      r_wrapped      <= 1'b0;
      r_err          <= 1'b0;
      r_err_idx      <= '0;
      r_err_expected <= '0;
      r_err_got      <= '0;
    end else if (w_accept) begin
      if (!w_lane0_ok) begin
        r_state        <= HALT;
        r_err          <= 1'b1;
        r_err_idx      <= r_count;
        r_err_expected <= r_a;
        r_err_got      <= in_num0;
      end else if (in_two && !w_lane1_ok) begin
        r_state        <= HALT;
        r_err          <= 1'b1;
        r_err_idx      <= w_count_p1;
        r_err_expected <= r_b;
        r_err_got      <= in_num1;
        r_count        <= w_count_p1;
      end else begin
        r_a       <= w_next_a;
        r_b       <= w_next_b;
        r_wrapped <= r_wrapped | w_carry;
        r_count   <= in_two ? w_count_p2 : w_count_p1;
      end
    end
  end

  assign count        = r_count;
  assign wrapped      = r_wrapped;
  assign err          = r_err;
  assign err_idx      = r_err_idx;
  assign err_expected = r_err_expected;
  assign err_got      = r_err_got;

endmodule

// File: tb/tb_fibonacci_checker.sv
// Scoreboard bench for fibonacci_checker: directed cases plus randomized beats
// checked against a table-driven model of the expected sequence.
module tb_fibonacci_checker;

  typedef struct {
    int unsigned cnt;
    bit          err;
    int unsigned idx;
    int unsigned ex;
    int unsigned got;
    bit          wr;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic        in_two;
  logic [15:0] in_num0;
  logic [15:0] in_num1;
  logic [15:0] count;
  logic        wrapped;
  logic        err;
  logic [15:0] err_idx;
  logic [15:0] err_expected;
  logic [15:0] err_got;

  int unsigned seqMod[0:1023];
  exp_t        sbQ[$];
  int          checkCount = 0;
  int          errCount   = 0;

  int unsigned mCnt;
  bit          mErr;
  int unsigned mIdx;
  int unsigned mExp;
  int unsigned mGot;
  bit          mWrap;
  bit          mHalt;

  fibonacci_checker dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_two       (in_two),
    .in_num0      (in_num0),
    .in_num1      (in_num1),
    .count        (count),
    .wrapped      (wrapped),
    .err          (err),
    .err_idx      (err_idx),
    .err_expected (err_expected),
    .err_got      (err_got)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkVal(input string name, input int unsigned act, input int unsigned req);
    checkCount++;
    if (act != req) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic modelRestart();
    mCnt  = 0;
    mErr  = 0;
    mIdx  = 0;
    mExp  = 0;
    mGot  = 0;
    mWrap = 0;
    mHalt = 0;
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".count"},        count,        mCnt);
    checkVal({tag, ".err"},          err,          mErr);
    checkVal({tag, ".err_idx"},      err_idx,      mIdx);
    checkVal({tag, ".err_expected"}, err_expected, mExp);
    checkVal({tag, ".err_got"},      err_got,      mGot);
    checkVal({tag, ".wrapped"},      wrapped,      mWrap);
  endtask

  // Called at a falling edge; drives one cycle, updates the model and queues the expected result.
  task automatic applyStimulus(input bit v, input bit two, input logic [15:0] n0,
                               input logic [15:0] n1, input bit clr);
    exp_t e;
    in_valid = v;
    in_two   = two;
    in_num0  = n0;
    in_num1  = n1;
    clear    = clr;
    #1;
    checkVal("in_ready", in_ready, (!mHalt && !clr) ? 1 : 0);
    if (clr) begin
      modelRestart();
    end else if (v && !mHalt) begin
      if (n0 != seqMod[mCnt]) begin
        mErr = 1; mHalt = 1; mIdx = mCnt; mExp = seqMod[mCnt]; mGot = n0;
      end else if (two && n1 != seqMod[mCnt+1]) begin
        mErr = 1; mHalt = 1; mIdx = mCnt + 1; mExp = seqMod[mCnt+1]; mGot = n1;
        mCnt = mCnt + 1;
      end else begin
        if (seqMod[mCnt] + seqMod[mCnt+1] > 65535) mWrap = 1;
        if (two && (seqMod[mCnt] + 2 * seqMod[mCnt+1] > 65535)) mWrap = 1;
        mCnt = mCnt + (two ? 2 : 1);
      end
      e.cnt = mCnt; e.err = mErr; e.idx = mIdx; e.ex = mExp; e.got = mGot; e.wr = mWrap;
      sbQ.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: whenever the DUT takes a beat, compare its registered outputs one cycle later.
  initial begin
    bit   acc;
    exp_t e;
    forever begin
      @(posedge clk);
      acc = in_valid && in_ready && rst;
      @(negedge clk);
      if (acc) begin
        if (sbQ.size() == 0) begin
          checkVal("sb_unexpected_accept", 1, 0);
        end else begin
          e = sbQ.pop_front();
          checkVal("sb.count",        count,        e.cnt);
          checkVal("sb.err",          err,          e.err);
          checkVal("sb.err_idx",      err_idx,      e.idx);
          checkVal("sb.err_expected", err_expected, e.ex);
          checkVal("sb.err_got",      err_got,      e.got);
          checkVal("sb.wrapped",      wrapped,      e.wr);
          checkVal("sb.in_ready",     in_ready,     e.err ? 0 : 1);
        end
      end
    end
  end

  initial begin
    int          t1[6] = '{1, 1, 2, 3, 5, 8};
    int          t2[8] = '{1, 1, 2, 3, 5, 8, 13, 21};
    int          t3[4] = '{1, 1, 2, 4};
    int          r;
    bit          two;
    logic [15:0] n0;
    logic [15:0] n1;

    seqMod[0] = 1;
    seqMod[1] = 1;
    for (int i = 2; i < 1024; i++) seqMod[i] = (seqMod[i-1] + seqMod[i-2]) % 65536;
    modelRestart();

    rst = 1'b0; clear = 1'b0; in_valid = 1'b0; in_two = 1'b0; in_num0 = '0; in_num1 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("reset");
    checkVal("reset.in_ready", in_ready, 1);

    // Singles along the sequence
    for (int i = 0; i < 6; i++) applyStimulus(1, 0, 16'(t1[i]), 16'd0, 0);
    checkVal("t1.count", count, 6);
    checkVal("t1.err", err, 0);

    // Dual-rate beats
    applyStimulus(0, 0, 16'd0, 16'd0, 1);
    for (int i = 0; i < 8; i += 2) applyStimulus(1, 1, 16'(t2[i]), 16'(t2[i+1]), 0);
    checkVal("t2.count", count, 8);
    checkVal("t2.err", err, 0);

    // Lane0 mismatch on 4th single, then ignored beats while halted
    applyStimulus(0, 0, 16'd0, 16'd0, 1);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 16'(t3[i]), 16'd0, 0);
    checkVal("t3.err", err, 1);
    checkVal("t3.err_idx", err_idx, 3);
    checkVal("t3.err_expected", err_expected, 3);
    checkVal("t3.err_got", err_got, 4);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 16'd5, 16'd0, 0);
    checkOutput("t3.held");

    // Lane1 mismatch in a dual beat
    applyStimulus(0, 0, 16'd0, 16'd0, 1);
    applyStimulus(1, 1, 16'd1, 16'd1, 0);
    applyStimulus(1, 1, 16'd2, 16'd5, 0);
    checkVal("t4.err_idx", err_idx, 3);
    checkVal("t4.err_expected", err_expected, 3);
    checkVal("t4.err_got", err_got, 5);
    checkVal("t4.count", count, 3);

    // Asynchronous reset away from any clock edge
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    modelRestart();
    checkOutput("async_rst");
    checkVal("async_rst.in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // 25 correct singles cross the 16-bit wrap
    for (int i = 0; i < 25; i++) applyStimulus(1, 0, 16'(seqMod[i]), 16'd0, 0);
    checkVal("t5.wrapped", wrapped, 1);
    checkVal("t5.err", err, 0);
    checkVal("t5.count", count, 25);

    // clear beats a valid beat while halted
    applyStimulus(0, 0, 16'd0, 16'd0, 1);
    applyStimulus(1, 0, 16'd7, 16'd0, 0);
    applyStimulus(1, 0, 16'd1, 16'd0, 1);
    applyStimulus(1, 0, 16'd1, 16'd0, 0);
    applyStimulus(1, 0, 16'd1, 16'd0, 0);
    checkVal("t6.count", count, 2);
    checkVal("t6.err", err, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      r   = int'($urandom_range(0, 99));
      two = 1'($urandom_range(0, 1));
      if (mCnt > 900) begin
        applyStimulus(0, 0, 16'd0, 16'd0, 1);
      end else if (mHalt) begin
        if (r < 30) applyStimulus(1, two, 16'($urandom), 16'($urandom), 1);
        else        applyStimulus(1, two, 16'($urandom), 16'($urandom), 0);
      end else if (r < 3) begin
        applyStimulus(1, two, 16'(seqMod[mCnt]), 16'(seqMod[mCnt+1]), 1);
      end else if (r < 15) begin
        applyStimulus(0, two, 16'($urandom), 16'($urandom), 0);
      end else begin
        n0 = 16'(seqMod[mCnt]);
        n1 = 16'(seqMod[mCnt+1]);
        if (r >= 94)                n0 = n0 ^ 16'($urandom_range(1, 65535));
        else if (r >= 88 && two)    n1 = n1 ^ 16'($urandom_range(1, 65535));
        applyStimulus(1, two, n0, n1, 0);
      end
    end

    in_valid = 1'b0;
    clear    = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("final");
    checkVal("sb_leftover", sbQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
